// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO, its interface and
// the drain-side stream reader.
package fifo_pkg;

  // Cycles from r_en to data_out being valid on the FIFO read port.
  localparam int FIFO_RD_LATENCY = 1;

  // Defaults shared with synchronous_fifo and fifo_interface.
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 8;

  // Default width of the reader's pop counter.
  localparam int CNT_WIDTH  = 16;

  // Occupancy of the reader's 2-entry output buffer (0..2).
  typedef logic [1:0] occ_t;

  // True when issuing one more read cannot overflow the 2-entry buffer.
  // The load is words buffered plus the word in flight, less the word
  // leaving this cycle. It cannot go negative because a pop needs occ >= 1.
  function automatic logic can_issue(input occ_t occ, input logic inflight,
                                     input logic pop);
    logic [2:0] load;
    load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (load < 3'd2);
  endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry register FIFO that absorbs the FIFO read latency, so the reader
// can keep streaming while downstream applies backpressure.
module reader_skid_buf #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] head,
  output fifo_pkg::occ_t        count
);
  import fifo_pkg::*;

  logic [DATA_WIDTH-1:0] entry [2];
  logic                  head_ptr;
  logic                  tail_ptr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_WIDTH-1:0] word_reg;

      // Capture the incoming word when the tail points at this slot.
      always_ff @(posedge clk) begin
        if (rst) begin
          word_reg <= '0;
        end else if (wr && (tail_ptr == 1'(gi))) begin
          word_reg <= wdata;
        end
      end

      assign entry[gi] = word_reg;
    end
  endgenerate

  // Advance the pointers and the count. Write and read may coincide; the
  // caller never writes into a full buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count    <= '0;
    end else begin
      if (wr) tail_ptr <= ~tail_ptr;
      if (rd) head_ptr <= ~head_ptr;
      count <= count + {1'b0, wr} - {1'b0, rd};
    end
  end

  assign head = entry[head_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drain-side controller for synchronous_fifo. It pops words through the
// registered read port and presents them in order on a valid/ready stream.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = fifo_pkg::CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  pop_count
);
  import fifo_pkg::*;

  occ_t                 occ;
  logic                 pop;
  logic                 inflight_reg;
  logic [CNT_WIDTH-1:0] pop_count_reg;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // A read is only issued when its word is guaranteed a buffer slot when it
  // lands next cycle. m_ready feeds this path directly, so reads resume in
  // the same cycle that backpressure is released.
  assign fifo_r_en = !rst && enable && !fifo_empty
                     && can_issue(occ, inflight_reg, pop);

  reader_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (inflight_reg),
    .wdata (fifo_data),
    .rd    (pop),
    .head  (m_data),
    .count (occ)
  );

  // Track the read in flight and count every read issued; the counter wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_reg  <= 1'b0;
      pop_count_reg <= '0;
    end else begin
      inflight_reg <= fifo_r_en;
      if (fifo_r_en) pop_count_reg <= pop_count_reg + CNT_WIDTH'(1);
    end
  end

  assign pop_count = pop_count_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader. The FIFO is a small behavioural model
// with a registered read port.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready = 1'b0;
  logic [CNT_WIDTH-1:0]  pop_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_r_en  (fifo_r_en),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .pop_count  (pop_count)
  );

  // Behavioural 8-deep FIFO with registered read data, reset with rst.
  logic [7:0] fmem [8];
  logic [2:0] frp, fwp;
  logic [3:0] fcnt;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       do_wr, do_rd;

  assign fifo_empty = (fcnt == 4'd0);
  assign do_wr = push && (fcnt != 4'd8);
  assign do_rd = fifo_r_en && (fcnt != 4'd0);

  always @(posedge clk) begin
    if (rst) begin
      frp <= '0; fwp <= '0; fcnt <= '0; fifo_data <= '0;
    end else begin
      if (do_rd) begin
        fifo_data <= fmem[frp];
        frp <= frp + 3'd1;
      end
      if (do_wr) begin
        fmem[fwp] <= push_data;
        fwp <= fwp + 3'd1;
      end
      fcnt <= fcnt + {3'b000, do_wr} - {3'b000, do_rd};
    end
  end

  // Stream monitor: records accepted words, counts reads, flags underflow.
  logic [7:0] rcv [256];
  int         rcv_n = 0;
  int         rd_n = 0;
  logic       underflow_seen = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (rcv_n < 256) rcv[rcv_n] <= m_data;
        rcv_n <= rcv_n + 1;
      end
      if (fifo_r_en) rd_n <= rd_n + 1;
      if (fifo_r_en && fifo_empty) underflow_seen <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Push 8 consecutive words starting at base; call at a negedge.
  task automatic fill(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      push_data = base + 8'(i);
      @(negedge clk);
    end
    push = 1'b0;
  endtask

  task automatic push_word(input logic [7:0] d);
    push = 1'b1;
    push_data = d;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int base, input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) chk(tag, 32'(rcv[base + i]), 32'(first + 8'(i)));
  endtask

  initial begin
    logic [11:0] ren_v;
    logic [11:0] val_v;
    int r0;
    int rd0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_r_en", 32'(fifo_r_en), 32'h0);
    chk("rst_m_valid", 32'(m_valid), 32'h0);
    chk("rst_m_data", 32'(m_data), 32'h0);
    chk("rst_pop_count", 32'(pop_count), 32'h0);

    // Full-rate streaming of 0x11..0x18.
    @(negedge clk);
    rst = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    fill(8'h11);
    chk("t1_filled", 32'(fifo_empty), 32'h0);
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      ren_v[k] = fifo_r_en;
      val_v[k] = m_valid;
      if (k >= 2 && k <= 9) chk("t1_data", 32'(m_data), 32'(8'h11 + 8'(k - 2)));
      @(negedge clk);
    end
    #1;
    chk("t1_r_en_pattern", 32'(ren_v), 32'h0FF);
    chk("t1_valid_pattern", 32'(val_v), 32'h3FC);
    chk("t1_pop_count", 32'(pop_count), 32'd8);
    chk("t1_empty", 32'(fifo_empty), 32'h1);

    // Backpressure: only two reads while m_ready is low, then no gaps.
    enable = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    fill(8'h21);
    rd0 = rd_n;
    enable = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t2_reads_held", 32'(rd_n - rd0), 32'd2);
    chk("t2_valid_held", 32'(m_valid), 32'h1);
    chk("t2_data_held", 32'(m_data), 32'h21);
    @(negedge clk);
    #1;
    chk("t2_data_stable", 32'(m_data), 32'h21);
    r0 = rcv_n;
    m_ready = 1'b1;
    #1;
    chk("t2_resume_same_cycle", 32'(fifo_r_en), 32'h1);
    repeat (8) @(negedge clk);
    #1;
    chk("t2_no_gaps", 32'(rcv_n - r0), 32'd8);
    chk_seq("t2_order", r0, 8'h21, 8);
    chk("t2_pop_count", 32'(pop_count), 32'd16);

    // m_ready toggling every cycle with a full FIFO.
    enable = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    fill(8'h31);
    r0 = rcv_n;
    enable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      m_ready = ~m_ready;
    end
    #1;
    chk("t3_count", 32'(rcv_n - r0), 32'd8);
    chk_seq("t3_order", r0, 8'h31, 8);
    chk("t3_no_underflow", 32'(underflow_seen), 32'h0);
    chk("t3_pop_count", 32'(pop_count), 32'd24);

    // enable dropped one cycle after the first read.
    enable = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    fill(8'h41);
    r0 = rcv_n;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t4_issued_only", 32'(rcv_n - r0), 32'd1);
    chk("t4_first_word", 32'(rcv[r0]), 32'h41);
    chk("t4_pop_count", 32'(pop_count), 32'd25);
    repeat (3) @(negedge clk);
    #1;
    chk("t4_pop_frozen", 32'(pop_count), 32'd25);
    chk("t4_fifo_kept", 32'(fifo_empty), 32'h0);
    enable = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    chk("t4_resume_count", 32'(rcv_n - r0), 32'd8);
    chk_seq("t4_order", r0, 8'h41, 8);
    chk("t4_pop_count_end", 32'(pop_count), 32'd32);

    // Reset with one word buffered and one in flight.
    enable = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    fill(8'h51);
    r0 = rcv_n;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("t5_pre_valid", 32'(m_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("t5_r_en_in_rst", 32'(fifo_r_en), 32'h0);
    @(negedge clk);
    #1;
    chk("t5_valid_cleared", 32'(m_valid), 32'h0);
    chk("t5_pop_cleared", 32'(pop_count), 32'h0);
    rst = 1'b0;
    m_ready = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_nothing_emitted", 32'(rcv_n - r0), 32'd0);
    push_word(8'h61);
    push_word(8'h62);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_post_count", 32'(rcv_n - r0), 32'd2);
    chk_seq("t5_post_order", r0, 8'h61, 2);
    chk("t5_pop_count", 32'(pop_count), 32'd2);

    // pop_count wrap: 65535 reads, then two more.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd0 = rd_n;
    for (int i = 0; i < 65535; i++) begin
      push = 1'b1;
      push_data = i[7:0];
      @(negedge clk);
    end
    push = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t6_reads", 32'(rd_n - rd0), 32'd65535);
    chk("t6_pop_ffff", 32'(pop_count), 32'hFFFF);
    push_word(8'hA0);
    @(negedge clk);
    #1;
    chk("t6_pop_wrap0", 32'(pop_count), 32'h0000);
    push_word(8'hA1);
    @(negedge clk);
    #1;
    chk("t6_pop_wrap1", 32'(pop_count), 32'h0001);
    chk("t6_no_underflow", 32'(underflow_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
